// File: rtl/operand_fetch_if.sv
// Handshake and bus bundle between the operand-fetch block and its upstream driver.
// The slave side is the fetch block; the master side supplies writes, fetch requests and ack.
interface operand_fetch_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
);
    logic              write;
    logic [AW-1:0]     writenum;
    logic [DATA_W-1:0] data_in;
    logic              start;
    logic [AW-1:0]     rn;
    logic [AW-1:0]     rm;
    logic [1:0]        shift_in;
    logic              ack;
    logic              busy;
    logic              valid;
    logic [DATA_W-1:0] A_out;
    logic [DATA_W-1:0] B_out;
    logic [1:0]        shift_out;

    modport master (
        output write, writenum, data_in, start, rn, rm, shift_in, ack,
        input  busy, valid, A_out, B_out, shift_out
    );

    modport slave (
        input  write, writenum, data_in, start, rn, rm, shift_in, ack,
        output busy, valid, A_out, B_out, shift_out
    );
endinterface

// File: rtl/operand_fetch.sv
// Register file with a single read port and a sequencer that fetches A then B,
// presenting both with the latched shift code under a valid/ack handshake.
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = 3
) (
    input logic           clk,
    input logic           reset,
    operand_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ_A, READ_B, VALID} state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [AW-1:0]     rn_q;
    logic [AW-1:0]     rm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        shift_q;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              capture;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return int'(addr) < NREGS;
    endfunction

    assign capture = bus.start && ((state == IDLE) || ((state == VALID) && bus.ack));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = READ_A;
            READ_A:  next_state = READ_B;
            READ_B:  next_state = VALID;
            VALID:   if (bus.ack) next_state = bus.start ? READ_A : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Single read port, steered by which operand is being fetched; a same-cycle
    // write to the read address is forwarded so the fetch sees the new value.
    always_comb begin
        rd_addr = (state == READ_B) ? rm_q : rn_q;
        rd_data = '0;
        if (in_range(rd_addr)) begin
            if (bus.write && (bus.writenum == rd_addr)) rd_data = bus.data_in;
            else                                        rd_data = regs[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.write && in_range(bus.writenum)) begin
            regs[bus.writenum] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            if (capture) begin
                rn_q    <= bus.rn;
                rm_q    <= bus.rm;
                shift_q <= bus.shift_in;
            end
            if (state == READ_A) a_q <= rd_data;
            if (state == READ_B) b_q <= rd_data;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.valid     = (state == VALID);
    assign bus.A_out     = a_q;
    assign bus.B_out     = b_q;
    assign bus.shift_out = shift_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: register writes, fetch latency, ack hold,
// forwarding, back-to-back fetch, mid-fetch reset and out-of-range writes.
module tb_operand_fetch;
    localparam int DATA_W = 16;
    localparam int NREGS  = 6;
    localparam int AW     = 3;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    operand_fetch_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    operand_fetch #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] num, input logic [DATA_W-1:0] d);
        bus.write    = 1'b1;
        bus.writenum = num;
        bus.data_in  = d;
        step();
        bus.write    = 1'b0;
    endtask

    // Issues a fetch from IDLE and leaves the block sitting in VALID.
    task automatic fetch(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [1:0] sh);
        bus.start    = 1'b1;
        bus.rn       = a;
        bus.rm       = b;
        bus.shift_in = sh;
        step();
        bus.start    = 1'b0;
        step();
        step();
    endtask

    task automatic release_ack();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        bus.write    = 1'b0;
        bus.writenum = '0;
        bus.data_in  = '0;
        bus.start    = 1'b0;
        bus.rn       = '0;
        bus.rm       = '0;
        bus.shift_in = 2'b00;
        bus.ack      = 1'b0;
        step();
        step();
        reset = 1'b0;

        // 1: reset state and basic fetch latency
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_a", 32'(bus.A_out), 32'h0);
        check("rst_b", 32'(bus.B_out), 32'h0);
        check("rst_shift", 32'(bus.shift_out), 32'd0);
        wr(3'd3, 16'h0005);
        wr(3'd5, 16'hA455);
        bus.start = 1'b1; bus.rn = 3'd3; bus.rm = 3'd5; bus.shift_in = 2'b01;
        step();
        bus.start = 1'b0;
        check("t1_busy_ra", 32'(bus.busy), 32'd1);
        check("t1_valid_ra", 32'(bus.valid), 32'd0);
        check("t1_shift_ra", 32'(bus.shift_out), 32'd1);
        step();
        check("t1_a_rb", 32'(bus.A_out), 32'h0005);
        check("t1_valid_rb", 32'(bus.valid), 32'd0);
        step();
        check("t1_valid", 32'(bus.valid), 32'd1);
        check("t1_a", 32'(bus.A_out), 32'h0005);
        check("t1_b", 32'(bus.B_out), 32'hA455);
        check("t1_shift", 32'(bus.shift_out), 32'd1);

        // 2: ack held low for 5 cycles while R5 is rewritten
        bus.write = 1'b1; bus.writenum = 3'd5; bus.data_in = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.write = 1'b0;
            check("t2_valid_hold", 32'(bus.valid), 32'd1);
            check("t2_a_hold", 32'(bus.A_out), 32'h0005);
            check("t2_b_hold", 32'(bus.B_out), 32'hA455);
        end
        release_ack();
        check("t2_idle_valid", 32'(bus.valid), 32'd0);
        check("t2_idle_busy", 32'(bus.busy), 32'd0);
        fetch(3'd5, 3'd3, 2'b00);
        check("t2_new_a", 32'(bus.A_out), 32'h1234);
        check("t2_new_b", 32'(bus.B_out), 32'h0005);
        release_ack();

        // 3: rn == rm with a write to that register during READ_B
        wr(3'd2, 16'h7777);
        bus.start = 1'b1; bus.rn = 3'd2; bus.rm = 3'd2; bus.shift_in = 2'b10;
        step();
        bus.start = 1'b0;
        step();
        bus.write = 1'b1; bus.writenum = 3'd2; bus.data_in = 16'h8000;
        step();
        bus.write = 1'b0;
        check("t3_valid", 32'(bus.valid), 32'd1);
        check("t3_a_old", 32'(bus.A_out), 32'h7777);
        check("t3_b_fwd", 32'(bus.B_out), 32'h8000);
        check("t3_shift", 32'(bus.shift_out), 32'd2);

        // 4: back-to-back fetch with ack and start together in VALID
        wr(3'd0, 16'h0101);
        wr(3'd1, 16'h0202);
        check("t4_still_valid", 32'(bus.valid), 32'd1);
        bus.ack = 1'b1; bus.start = 1'b1; bus.rn = 3'd0; bus.rm = 3'd1; bus.shift_in = 2'b11;
        step();
        bus.ack = 1'b0; bus.start = 1'b0;
        check("t4_c1_valid", 32'(bus.valid), 32'd0);
        check("t4_c1_busy", 32'(bus.busy), 32'd1);
        check("t4_c1_shift", 32'(bus.shift_out), 32'd3);
        check("t4_c1_a_hold", 32'(bus.A_out), 32'h7777);
        step();
        check("t4_c2_valid", 32'(bus.valid), 32'd0);
        check("t4_c2_busy", 32'(bus.busy), 32'd1);
        check("t4_c2_a", 32'(bus.A_out), 32'h0101);
        step();
        check("t4_valid", 32'(bus.valid), 32'd1);
        check("t4_a", 32'(bus.A_out), 32'h0101);
        check("t4_b", 32'(bus.B_out), 32'h0202);
        release_ack();

        // 5: reset asserted during READ_B
        bus.start = 1'b1; bus.rn = 3'd0; bus.rm = 3'd1; bus.shift_in = 2'b01;
        step();
        bus.start = 1'b0;
        step();
        check("t5_in_rb_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_valid", 32'(bus.valid), 32'd0);
        check("t5_a", 32'(bus.A_out), 32'h0);
        check("t5_b", 32'(bus.B_out), 32'h0);
        check("t5_shift", 32'(bus.shift_out), 32'd0);
        for (int r = 0; r < NREGS; r += 2) begin
            fetch(AW'(r), AW'(r + 1), 2'b00);
            check("t5_reg_even", 32'(bus.A_out), 32'h0);
            check("t5_reg_odd", 32'(bus.B_out), 32'h0);
            release_ack();
        end

        // 6: start held through READ_A, then out-of-range writes
        wr(3'd4, 16'h4444);
        wr(3'd6, 16'hFFFF);
        wr(3'd7, 16'hEEEE);
        bus.start = 1'b1; bus.rn = 3'd4; bus.rm = 3'd4; bus.shift_in = 2'b10;
        step();
        bus.rn = 3'd0; bus.rm = 3'd0; bus.shift_in = 2'b11;
        step();
        bus.start = 1'b0;
        check("t6_ra_busy", 32'(bus.busy), 32'd1);
        check("t6_ra_valid", 32'(bus.valid), 32'd0);
        check("t6_ra_a", 32'(bus.A_out), 32'h4444);
        check("t6_ra_shift", 32'(bus.shift_out), 32'd2);
        step();
        check("t6_valid", 32'(bus.valid), 32'd1);
        check("t6_b", 32'(bus.B_out), 32'h4444);
        release_ack();
        check("t6_single_fetch", 32'(bus.busy), 32'd0);
        fetch(3'd0, 3'd1, 2'b00);
        check("t6_r0", 32'(bus.A_out), 32'h0);
        check("t6_r1", 32'(bus.B_out), 32'h0);
        release_ack();
        fetch(3'd2, 3'd3, 2'b00);
        check("t6_r2", 32'(bus.A_out), 32'h0);
        check("t6_r3", 32'(bus.B_out), 32'h0);
        release_ack();
        fetch(3'd5, 3'd4, 2'b00);
        check("t6_r5", 32'(bus.A_out), 32'h0);
        check("t6_r4", 32'(bus.B_out), 32'h4444);
        release_ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
